ahfp_add_multi: RTL
===================

Name: ahfp_add_multi

Overview:
- Multi-cycle IEEE-754 single-precision floating-point adder, result = dataa + datab.
- Companion to the combinational subtractor in the ahfp family.
- Exposed as a Nios II multi-cycle custom instruction (clk, clk_en, reset, start, done).
- Fixed 4-cycle latency FSM. Truncation rounding and denormal flush-to-zero, consistent with the rest of the ahfp units.

Parameters:
- GUARD, 3, extra low-order mantissa bits carried through align/add/normalise. They are dropped (truncated) at pack.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears FSM and outputs
- clk_en  input  1  clock enable; when low all registers hold
- start  input  1  one-cycle request; operands valid in the same cycle
- dataa  input  32  operand A, IEEE-754 single
- datab  input  32  operand B, IEEE-754 single
- result  output  32  registered sum; valid when done=1, held until next done
- done  output  1  one-cycle pulse marking result valid

Behaviour:
- Reset (reset=1 at a rising edge, regardless of clk_en):
  - state=IDLE, done=0, result=32'h0, all internal registers 0.
  - Reset mid-operation aborts the operation. No done is issued for it.
- clk_en=0: state, internal registers, result and done all hold. A start sampled while clk_en=0 is ignored.
- FSM states and transitions (each step requires clk_en=1):
  - IDLE -> ALIGN on start. start in any other state is ignored; there is no queueing.
  - ALIGN -> ADD -> NORM -> PACK -> IDLE, one step per enabled cycle.
- IDLE capture (on start):
  - Unpack each operand into sign, exp[7:0] and mantissa m[23+GUARD:0] = {hidden,frac,GUARD zeros}.
  - exp==0: operand is treated as zero (hidden=0, frac forced 0), i.e. denormals are flushed.
  - exp==255 on either operand: set special flag (see PACK).
- ALIGN:
  - Order operands by magnitude {exp,frac}; the larger becomes L. On equal magnitude A is L.
  - d = L.exp - S.exp. S.m is shifted right by d, zero-fill, no sticky. d >= 24+GUARD gives S.m = 0.
- ADD:
  - Same signs: sum = L.m + S.m, width 25+GUARD bits with carry.
  - Different signs: sum = L.m - S.m, never negative.
  - Result sign = L.sign. Working exponent e = L.exp, 10-bit signed.
- NORM:
  - Carry bit set: sum >>= 1, e += 1.
  - Else sum == 0: zero flag.
  - Else: lz = leading zeros above hidden position; sum <<= lz, e -= lz. Single-cycle leading-zero count.
- PACK (priority order):
  1. special: if both inputs are exp==255 with opposite signs, result = 32'h7FC00000. Otherwise result = {sign of the exp==255 operand (A if both), 8'hFF, 23'h0}.
  2. zero flag: result = 32'h00000000 (+0, even for -x + x and for -0 + -0).
  3. e >= 255: result = {sign, 8'hFF, 23'h0}.
  4. e <= 0: result = {sign, 31'h0} (flush).
  5. Otherwise: result = {sign, e[7:0], sum[22+GUARD:GUARD]}.
  - done=1 for exactly this one cycle, then state returns to IDLE.
- Latency:
  - start accepted at enabled edge N gives done=1 and result valid after enabled edge N+4.
  - With clk_en continuously high, that is 4 cycles.
  - Back-to-back: the next start is accepted in the cycle done is high (state IDLE only after PACK), so throughput is one op per 5 cycles.
- result holds its value between done pulses. done is never high for two consecutive cycles.

Test Plan:
1. Addition with carry: start with 3F800000 + 3F800000 (1.0 + 1.0) -> done pulses exactly 4 cycles later with result 40000000; result held afterwards.
2. Cancellation and sign: 3FC00000 + BF800000 (1.5 + -1.0) -> 3F000000. Then 3F800000 + BF800000 -> 00000000. Then C0400000 + 3F800000 (-3 + 1) -> C0000000.
3. Alignment and truncation: 4B800000 + 3F800000 (2^24 + 1) -> 4B800000. Then 3F800000 + 33800000 (1 + 2^-24) -> 3F800000. Denormal 00000001 + 3F800000 -> 3F800000.
4. Overflow and specials: 7F7FFFFF + 7F7FFFFF -> 7F800000. 7F800000 + FF800000 -> 7FC00000. FF800000 + 3F800000 -> FF800000.
5. Control:
   - start asserted in ALIGN/ADD is ignored, and the first result completes unchanged.
   - clk_en low for 3 cycles during NORM extends done by exactly 3 cycles.
   - reset pulse during ADD gives no done, result=0; a fresh start afterwards completes normally in 4 cycles.

Source files
------------

// File: rtl/ahfp_add_multi_if.sv
// Purpose : custom-instruction handshake bundle for ahfp_add_multi (enable, request, operands, sum, done).
// Latency : n/a (wires only).
// Backpressure: none; the requester keeps start low until done has pulsed.
// Ports:
//   clk_en        clock enable for every register in the adder
//   start         one-cycle request, dataa/datab valid in the same cycle
//   dataa, datab  IEEE-754 single operands
//   result        registered sum, valid with done
//   done          one-cycle completion pulse
interface ahfp_add_multi_if;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;
  logic        done;

  modport master (
    output clk_en, start, dataa, datab,
    input  result, done
  );

  modport slave (
    input  clk_en, start, dataa, datab,
    output result, done
  );
endinterface

// File: rtl/ahfp_add_multi.sv
// Purpose : multi-cycle IEEE-754 single adder (result = dataa + datab), truncating, denormals flushed.
// Latency : fixed 4 enabled cycles from start to done; one op per 5 cycles back-to-back.
// Backpressure: none; start is only accepted in IDLE, clk_en low freezes every register.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high, clears FSM, datapath and outputs regardless of clk_en
//   bus    ahfp_add_multi_if.slave (clk_en, start, dataa, datab -> result, done)
module ahfp_add_multi #(
  parameter int GUARD = 3
) (
  input  logic              clk,
  input  logic              reset,
  ahfp_add_multi_if.slave   bus
);

  localparam int MW  = 24 + GUARD;      // mantissa width incl. hidden bit and guard bits
  localparam int LZW = $clog2(MW + 1);  // wide enough to count every bit of a mantissa

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    PACK  = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Captured operands
  logic          a_sign, b_sign;
  logic [7:0]    a_exp, b_exp;
  logic [MW-1:0] a_m, b_m;

  // Infinity/NaN inputs are resolved at pack time from these captured flags
  logic          spec, spec_nan, spec_sign;

  // Aligned operands
  logic          l_sign;
  logic [7:0]    l_exp;
  logic [MW-1:0] l_m, s_m;
  logic          eff_sub;

  // Working sum (top bit is the carry) and exponent
  logic          r_sign;
  logic [MW:0]   sum;
  logic signed [9:0] e;
  logic          zero;

  logic [31:0]   result_q, result_nxt;
  logic          done_q, done_nxt;

  // ---------------------------------------------------------------------------
  // Unpack: exponent 0 means zero, which also flushes denormals
  // ---------------------------------------------------------------------------
  logic [7:0]    in_a_exp, in_b_exp;
  logic [MW-1:0] in_a_m, in_b_m;

  always_comb begin
    in_a_exp = bus.dataa[30:23];
    in_b_exp = bus.datab[30:23];
    in_a_m   = (in_a_exp == 8'd0) ? '0 : {1'b1, bus.dataa[22:0], {GUARD{1'b0}}};
    in_b_m   = (in_b_exp == 8'd0) ? '0 : {1'b1, bus.datab[22:0], {GUARD{1'b0}}};
  end

  // ---------------------------------------------------------------------------
  // Align: larger magnitude becomes L (A wins ties), smaller is shifted right
  // without sticky; shifts past the whole mantissa leave nothing.
  // ---------------------------------------------------------------------------
  logic          a_is_l;
  logic [7:0]    al_exp, as_exp, d;
  logic [MW-1:0] al_m, as_m, as_shift;

  always_comb begin
    a_is_l   = ({a_exp, a_m} >= {b_exp, b_m});
    al_exp   = a_is_l ? a_exp : b_exp;
    as_exp   = a_is_l ? b_exp : a_exp;
    al_m     = a_is_l ? a_m   : b_m;
    as_m     = a_is_l ? b_m   : a_m;
    d        = al_exp - as_exp;
    as_shift = (d >= 8'(MW)) ? '0 : (as_m >> d);
  end

  // ---------------------------------------------------------------------------
  // Add: L >= S in magnitude, so the subtraction never goes negative
  // ---------------------------------------------------------------------------
  logic [MW:0] sum_add;

  always_comb begin
    if (eff_sub)
      sum_add = {1'b0, l_m} - {1'b0, s_m};
    else
      sum_add = {1'b0, l_m} + {1'b0, s_m};
  end

  // ---------------------------------------------------------------------------
  // Normalise: leading zeros counted below the carry bit
  // ---------------------------------------------------------------------------
  function automatic logic [LZW-1:0] lzc(input logic [MW-1:0] v);
    logic found;
    lzc   = '0;
    found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      lzc   = lzc + 1'b1;
      end
    end
  endfunction

  logic [LZW-1:0] lz;

  always_comb begin
    lz = lzc(sum[MW-1:0]);
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else if (bus.clk_en)
      state <= state_nxt;
  end

  // FSM: next-state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = ALIGN;
      ALIGN:   state_nxt = ADD;
      ADD:     state_nxt = NORM;
      NORM:    state_nxt = PACK;
      PACK:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs. The packed word and done are computed in PACK and land in
  // their registers on the edge that returns the FSM to IDLE.
  always_comb begin
    done_nxt   = 1'b0;
    result_nxt = result_q;
    if (state == PACK) begin
      done_nxt = 1'b1;
      if (spec) begin
        if (spec_nan) result_nxt = 32'h7FC0_0000;
        else          result_nxt = {spec_sign, 8'hFF, 23'h0};
      end else if (zero) begin
        result_nxt = 32'h0000_0000;
      end else if (e >= 10'sd255) begin
        result_nxt = {r_sign, 8'hFF, 23'h0};
      end else if (e <= 10'sd0) begin
        result_nxt = {r_sign, 31'h0};
      end else begin
        result_nxt = {r_sign, e[7:0], sum[22+GUARD:GUARD]};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sign    <= 1'b0;
      b_sign    <= 1'b0;
      a_exp     <= '0;
      b_exp     <= '0;
      a_m       <= '0;
      b_m       <= '0;
      spec      <= 1'b0;
      spec_nan  <= 1'b0;
      spec_sign <= 1'b0;
      l_sign    <= 1'b0;
      l_exp     <= '0;
      l_m       <= '0;
      s_m       <= '0;
      eff_sub   <= 1'b0;
      r_sign    <= 1'b0;
      sum       <= '0;
      e         <= '0;
      zero      <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else if (bus.clk_en) begin
      result_q <= result_nxt;
      done_q   <= done_nxt;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sign    <= bus.dataa[31];
            b_sign    <= bus.datab[31];
            a_exp     <= in_a_exp;
            b_exp     <= in_b_exp;
            a_m       <= in_a_m;
            b_m       <= in_b_m;
            spec      <= (in_a_exp == 8'hFF) || (in_b_exp == 8'hFF);
            spec_nan  <= (in_a_exp == 8'hFF) && (in_b_exp == 8'hFF) &&
                         (bus.dataa[31] != bus.datab[31]);
            // A's sign wins when both are infinite
            spec_sign <= (in_a_exp == 8'hFF) ? bus.dataa[31] : bus.datab[31];
            zero      <= 1'b0;
          end
        end
        ALIGN: begin
          l_sign  <= a_is_l ? a_sign : b_sign;
          l_exp   <= al_exp;
          l_m     <= al_m;
          s_m     <= as_shift;
          eff_sub <= a_sign ^ b_sign;
        end
        ADD: begin
          sum    <= sum_add;
          e      <= $signed({2'b00, l_exp});
          r_sign <= l_sign;
        end
        NORM: begin
          if (sum[MW]) begin
            sum <= sum >> 1;
            e   <= e + 10'sd1;
          end else if (sum == '0) begin
            zero <= 1'b1;
          end else begin
            sum <= sum << lz;
            e   <= e - $signed(10'(lz));
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;

endmodule
